pipe_stage_reg: RTL

- Parametrised pipeline stage register, successor to the single-enable stage latches between fetch/decode/execute.
- Carries NUM_FIELDS fields of DATA_W bits each, e.g. PC+4 and instruction.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and hazard-unit stall and flush.
- Flushed or empty slots present a programmable bubble (NOP) value downstream.

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// hazard stall/flush, and a programmable bubble value on empty slots.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 2,
    localparam int TOT_W     = DATA_W * NUM_FIELDS,
    parameter logic [TOT_W-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOT_W-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [7:0]       flush_count
);

    // state | meaning
    // EMPTY | nothing held
    // ONE   | main register holds the head entry
    // TWO   | main holds head, skid holds the next entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [TOT_W-1:0]  mainData;
    logic [TOT_W-1:0]  skidData;
    logic              inReadyReg;
    logic              acc;
    logic              emt;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkidIn;
    logic [8:0]        fcSum;

    assign acc = in_valid && inReadyReg && !stall;
    assign emt = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            inReadyReg <= 1'b0;
        end else begin
            state      <= nextState;
            inReadyReg <= (nextState != TWO);
        end
    end

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkidIn   = 1'b0;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        nextState  = ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !emt) begin
                        nextState  = TWO;
                        loadSkidIn = 1'b1;
                    end else if (acc && emt) begin
                        loadMainIn = 1'b1;
                    end else if (emt) begin
                        nextState = EMPTY;
                    end
                end
                TWO: begin
                    if (emt) begin
                        nextState    = ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: nextState = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state != EMPTY) && !stall;
        out_data  = out_valid ? mainData : BUBBLE_VAL;
        in_ready  = inReadyReg;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Flushed slots are scrubbed to the bubble so stale entries never resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= BUBBLE_VAL;
            skidData <= BUBBLE_VAL;
        end else if (flush) begin
            mainData <= BUBBLE_VAL;
            skidData <= BUBBLE_VAL;
        end else begin
            if (loadMainIn) begin
                mainData <= in_data;
            end else if (loadMainSkid) begin
                mainData <= skidData;
            end
            if (loadSkidIn) begin
                skidData <= in_data;
            end
        end
    end

    assign fcSum = {1'b0, flush_count} + {7'd0, occupancy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_count <= 8'd0;
        end else if (flush) begin
            flush_count <= fcSum[8] ? 8'hFF : fcSum[7:0];
        end
    end

endmodule
